// File: rtl/btle_tx_if.sv
// Bit-stream handshake between the BLE transmitter and the GFSK modulator.
// One bit moves on every cycle where bit_valid and bit_ready are both high.
interface btle_tx_if;
    logic bit_out;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_out,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_out,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/btle_tx.sv
// BLE link-layer bit transmitter: preamble, access address, whitened PDU and
// whitened CRC24 are serialized from an internal octet RAM onto a valid/ready stream.
module btle_tx #(
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int PDU_ADDR_WIDTH           = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  access_address,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    input  logic                                pdu_octet_mem_wr_en,
    input  logic [PDU_ADDR_WIDTH-1:0]           pdu_octet_mem_addr,
    input  logic [7:0]                          pdu_octet_mem_data,
    input  logic                                start,
    btle_tx_if.master                           bit_if,
    output logic                                tx_busy,
    output logic                                tx_done,
    output logic [6:0]                          payload_length
);

    localparam int CNT_W = $clog2(LEN_UNIQUE_BIT_SEQUENCE);
    localparam int OCT_W = PDU_ADDR_WIDTH + 1;
    localparam int WH_W  = CHANNEL_NUMBER_BIT_WIDTH + 1;
    localparam logic [6:0] MAX_LEN = 7'((1 << PDU_ADDR_WIDTH) - 2);
    localparam logic [CRC_STATE_BIT_WIDTH-1:0] CRC_POLY = CRC_STATE_BIT_WIDTH'(24'h00065B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_FETCH,
        S_PREAMBLE,
        S_ACCESS,
        S_PDU,
        S_CRC,
        S_DONE
    } state_t;

    state_t                               state_q, state_d;
    logic                                 phase_q, phase_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [OCT_W-1:0]                     octet_idx_q, octet_idx_d;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]   sr_q, sr_d;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]   aa_q, aa_d;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]  ch_q, ch_d;
    logic [CRC_STATE_BIT_WIDTH-1:0]       crc_q, crc_d;
    logic [WH_W-1:0]                      wh_q, wh_d;
    logic [6:0]                           len_q, len_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 valid_q, valid_d;
    logic                                 bit_out_q, bit_out_d;

    logic [7:0]                           mem [0:(1 << PDU_ADDR_WIDTH)-1];
    logic [7:0]                           rd_data_q;
    logic                                 rd_en;
    logic [PDU_ADDR_WIDTH-1:0]            rd_addr;

    logic                                 hs;
    logic [WH_W-1:0]                      wh_seed;
    logic [WH_W-1:0]                      wh_adv;
    logic [CRC_STATE_BIT_WIDTH-1:0]       crc_adv;
    logic                                 crc_fb;
    logic [6:0]                           len_sat;
    logic [7:0]                           preamble;

    assign hs = valid_q & bit_if.bit_ready;

    // Whitening seed: position 0 is 1, positions 1..6 carry the channel MSB first.
    assign wh_seed[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < CHANNEL_NUMBER_BIT_WIDTH; gi++) begin : g_wh_seed
            assign wh_seed[gi+1] = ch_q[CHANNEL_NUMBER_BIT_WIDTH-1-gi];
        end
    endgenerate

    // x^7 + x^4 + 1: the output tap (position 6) feeds position 0 and position 4.
    generate
        for (gi = 0; gi < WH_W; gi++) begin : g_wh_adv
            if (gi == 0) begin : g_head
                assign wh_adv[gi] = wh_q[WH_W-1];
            end else if (gi == 4) begin : g_tap
                assign wh_adv[gi] = wh_q[gi-1] ^ wh_q[WH_W-1];
            end else begin : g_shift
                assign wh_adv[gi] = wh_q[gi-1];
            end
        end
    endgenerate

    assign crc_fb  = crc_q[CRC_STATE_BIT_WIDTH-1] ^ sr_q[0];
    assign crc_adv = {crc_q[CRC_STATE_BIT_WIDTH-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

    assign len_sat  = (rd_data_q[6:0] > MAX_LEN) ? MAX_LEN : rd_data_q[6:0];
    assign preamble = aa_q[0] ? 8'h55 : 8'hAA;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        octet_idx_d = octet_idx_q;
        sr_d        = sr_q;
        aa_d        = aa_q;
        ch_d        = ch_q;
        crc_d       = crc_q;
        wh_d        = wh_q;
        len_d       = len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        rd_en       = 1'b0;
        rd_addr     = '0;

        case (state_q)
            S_IDLE: begin
                phase_d = 1'b0;
                if (start) begin
                    aa_d    = access_address;
                    ch_d    = channel_number;
                    crc_d   = crc_state_init_bit;
                    busy_d  = 1'b1;
                    state_d = S_LEN_FETCH;
                end
            end

            // Two cycles: fetch the length octet, then latch it while prefetching octet 0.
            S_LEN_FETCH: begin
                rd_en = 1'b1;
                if (!phase_q) begin
                    rd_addr = PDU_ADDR_WIDTH'(1);
                    phase_d = 1'b1;
                end else begin
                    rd_addr     = '0;
                    len_d       = len_sat;
                    sr_d        = '0;
                    sr_d[7:0]   = preamble;
                    cnt_d       = '0;
                    wh_d        = wh_seed;
                    valid_d     = 1'b1;
                    state_d     = S_PREAMBLE;
                end
            end

            S_PREAMBLE: begin
                if (hs) begin
                    if (cnt_q == CNT_W'(7)) begin
                        sr_d    = aa_q;
                        cnt_d   = '0;
                        state_d = S_ACCESS;
                    end else begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_ACCESS: begin
                if (hs) begin
                    if (cnt_q == CNT_W'(LEN_UNIQUE_BIT_SEQUENCE - 1)) begin
                        sr_d        = '0;
                        sr_d[7:0]   = rd_data_q;
                        cnt_d       = '0;
                        octet_idx_d = '0;
                        rd_en       = 1'b1;
                        rd_addr     = PDU_ADDR_WIDTH'(1);
                        state_d     = S_PDU;
                    end else begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // The octet after the current one is always waiting in rd_data_q.
            S_PDU: begin
                if (hs) begin
                    crc_d = crc_adv;
                    wh_d  = wh_adv;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (octet_idx_q == OCT_W'(len_q) + OCT_W'(1)) begin
                            state_d = S_CRC;
                        end else begin
                            sr_d        = '0;
                            sr_d[7:0]   = rd_data_q;
                            octet_idx_d = octet_idx_q + OCT_W'(1);
                            rd_en       = 1'b1;
                            rd_addr     = octet_idx_q[PDU_ADDR_WIDTH-1:0] + PDU_ADDR_WIDTH'(2);
                        end
                    end else begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_CRC: begin
                if (hs) begin
                    crc_d = crc_q << 1;
                    wh_d  = wh_adv;
                    if (cnt_q == CNT_W'(CRC_STATE_BIT_WIDTH - 1)) begin
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // bit_out is registered from the next state so it only changes on a handshake.
    always_comb begin
        bit_out_d = 1'b0;
        case (state_d)
            S_PREAMBLE, S_ACCESS: bit_out_d = sr_d[0];
            S_PDU:                bit_out_d = sr_d[0] ^ wh_d[WH_W-1];
            S_CRC:                bit_out_d = crc_d[CRC_STATE_BIT_WIDTH-1] ^ wh_d[WH_W-1];
            default:              bit_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            octet_idx_q <= '0;
            sr_q        <= '0;
            aa_q        <= '0;
            ch_q        <= '0;
            crc_q       <= '0;
            wh_q        <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            bit_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            octet_idx_q <= octet_idx_d;
            sr_q        <= sr_d;
            aa_q        <= aa_d;
            ch_q        <= ch_d;
            crc_q       <= crc_d;
            wh_q        <= wh_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            bit_out_q   <= bit_out_d;
        end
    end

    // Octet RAM: host writes are dropped while a frame is in flight.
    always_ff @(posedge clk) begin
        if (pdu_octet_mem_wr_en && !busy_q) begin
            mem[pdu_octet_mem_addr] <= pdu_octet_mem_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign bit_if.bit_out   = bit_out_q;
    assign bit_if.bit_valid = valid_q;
    assign tx_busy          = busy_q;
    assign tx_done          = done_q;
    assign payload_length   = len_q;

endmodule

// File: tb/tb_btle_tx.sv
// Scoreboard bench for btle_tx: each frame's expected bits are queued at start,
// and a negedge monitor pops one entry per accepted bit.
module tb_btle_tx;

    logic        clk;
    logic        rst;
    logic [31:0] aa;
    logic [5:0]  ch;
    logic [23:0] crc_init;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic        tx_busy;
    logic        tx_done;
    logic [6:0]  payload_length;

    btle_tx_if bus ();

    btle_tx dut (
        .clk                 (clk),
        .rst                 (rst),
        .access_address      (aa),
        .channel_number      (ch),
        .crc_state_init_bit  (crc_init),
        .pdu_octet_mem_wr_en (wr_en),
        .pdu_octet_mem_addr  (wr_addr),
        .pdu_octet_mem_data  (wr_data),
        .start               (start),
        .bit_if              (bus),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done),
        .payload_length      (payload_length)
    );

    int         checks = 0;
    int         errors = 0;
    int         hs_cnt = 0;
    int         done_cnt = 0;
    logic       exp_q[$];
    logic [7:0] ram_model [64];
    logic       ready_rand = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_bit = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // bit_ready is updated just after each rising edge
    initial begin : ready_driver
        bus.bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bit_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(bus.bit_valid && bus.bit_out == prev_bit)) begin
                        errors++;
                        $display("FAIL stall_hold: valid %0b bit %0b, expected valid 1 bit %0b",
                                 bus.bit_valid, bus.bit_out, prev_bit);
                    end
                end
                if (bus.bit_valid) begin
                    checks++;
                    if (tx_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_in_frame: got %0b, expected 1", tx_busy);
                    end
                end
                if (bus.bit_valid && bus.bit_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_bit: bit %0d got %0b, expected no bit", hs_cnt, bus.bit_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.bit_out !== e) begin
                            errors++;
                            $display("FAIL frame_bit[%0d]: got %0b, expected %0b", hs_cnt, bus.bit_out, e);
                        end
                    end
                    hs_cnt++;
                end
                if (tx_done) done_cnt++;
                prev_stall = bus.bit_valid && !bus.bit_ready;
                prev_bit   = bus.bit_out;
            end
        end
    end

    // Reference frame builder working on whitening/CRC register positions.
    task automatic push_frame(input logic [31:0] a, input logic [5:0] c, input logic [23:0] ci,
                              output int nbits, output int len);
        logic [7:0]  pre;
        logic [6:0]  w, nw;
        logic [23:0] r, nr;
        logic [23:0] taps;
        logic [6:0]  l7;
        logic [7:0]  oct;
        logic        d, fb;
        taps = 24'h00065B;
        pre  = a[0] ? 8'h55 : 8'hAA;
        for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(a[i]);
        l7  = ram_model[1][6:0];
        len = (int'(l7) > 62) ? 62 : int'(l7);
        w[0] = 1'b1;
        for (int k = 1; k < 7; k++) w[k] = c[6-k];
        r = ci;
        for (int k = 0; k < len + 2; k++) begin
            oct = ram_model[k];
            for (int i = 0; i < 8; i++) begin
                d = oct[i];
                exp_q.push_back(d ^ w[6]);
                fb = d ^ r[23];
                nr[0] = fb;
                for (int p = 1; p < 24; p++) nr[p] = r[p-1] ^ (fb & taps[p]);
                r = nr;
                nw[0] = w[6];
                for (int p = 1; p < 7; p++) nw[p] = w[p-1];
                nw[4] = w[3] ^ w[6];
                w = nw;
            end
        end
        for (int j = 23; j >= 0; j--) begin
            exp_q.push_back(r[j] ^ w[6]);
            nw[0] = w[6];
            for (int p = 1; p < 7; p++) nw[p] = w[p-1];
            nw[4] = w[3] ^ w[6];
            w = nw;
        end
        nbits = 64 + 8 * (2 + len);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        ram_model[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] a, input logic [5:0] c, input logic [23:0] ci,
                               output int nbits, output int len);
        int lat;
        push_frame(a, c, ci, nbits, len);
        hs_cnt   = 0;
        done_cnt = 0;
        aa       = a;
        ch       = c;
        crc_init = ci;
        start    = 1'b1;
        lat      = 0;
        do begin
            tick();
            lat++;
            start    = 1'b0;
            aa       = ~a;
            ch       = ~c;
            crc_init = ~ci;
            if (lat == 1) chk("busy_after_start", 32'(tx_busy), 32'd1);
        end while (!bus.bit_valid && lat < 10);
        chk("first_valid_latency", 32'(lat), 32'd3);
    endtask

    task automatic finish_frame(input string name, input int nbits, input int len);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
        chk({name, "_bits_sent"}, 32'(hs_cnt), 32'(nbits));
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({name, "_bits_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_payload_length"}, 32'(payload_length), 32'(len));
        chk({name, "_busy_after"}, 32'(tx_busy), 32'd0);
        $display("frame %s: %0d bits sent, payload_length %0d, tx_done pulses %0d",
                 name, hs_cnt, payload_length, done_cnt);
    endtask

    initial begin : stimulus
        int nbits, len, cyc;
        rst      = 1'b0;
        aa       = '0;
        ch       = '0;
        crc_init = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        repeat (3) tick();
        chk("reset_bit_out", 32'(bus.bit_out), 32'd0);
        chk("reset_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("reset_tx_busy", 32'(tx_busy), 32'd0);
        chk("reset_tx_done", 32'(tx_done), 32'd0);
        chk("reset_payload_length", 32'(payload_length), 32'd0);
        rst = 1'b1;
        tick();

        wr(6'd0, 8'h40);
        wr(6'd1, 8'h06);
        for (int k = 0; k < 6; k++) wr(6'(k + 2), 8'(k + 1));

        // Baseline frame, AA LSB 0 -> preamble 0xAA
        start_frame(32'h8E89BED6, 6'd37, 24'h555555, nbits, len);
        finish_frame("basic", nbits, len);
        chk("basic_len_const", 32'(nbits), 32'd128);

        // AA LSB 1 -> preamble 0x55
        start_frame(32'h8E89BED7, 6'd37, 24'h555555, nbits, len);
        finish_frame("preamble55", nbits, len);

        // Random backpressure
        ready_rand = 1'b1;
        start_frame(32'h8E89BED6, 6'd37, 24'h555555, nbits, len);
        finish_frame("backpressure", nbits, len);
        ready_rand = 1'b0;
        tick();

        // Write and start around bit 40 must both be ignored
        start_frame(32'h8E89BED6, 6'd37, 24'h555555, nbits, len);
        cyc = 0;
        while (hs_cnt < 40 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("mid_reached_bit40", 32'(hs_cnt >= 40), 32'd1);
        wr_en   = 1'b1;
        wr_addr = 6'd5;
        wr_data = 8'hEE;
        start   = 1'b1;
        aa      = 32'h12345679;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        finish_frame("mid_write_start", nbits, len);

        // Reset at bit 50, then a clean frame from the retained RAM
        start_frame(32'h8E89BED6, 6'd37, 24'h555555, nbits, len);
        cyc = 0;
        while (hs_cnt < 50 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("rst_reached_bit50", 32'(hs_cnt >= 50), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_bit_out", 32'(bus.bit_out), 32'd0);
        chk("midrst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("midrst_tx_busy", 32'(tx_busy), 32'd0);
        chk("midrst_tx_done", 32'(tx_done), 32'd0);
        chk("midrst_payload_length", 32'(payload_length), 32'd0);
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        $display("frame reset_abort: aborted after %0d bits", hs_cnt);
        start_frame(32'h8E89BED6, 6'd37, 24'h555555, nbits, len);
        finish_frame("after_reset", nbits, len);

        // Oversized length saturates to 62
        wr(6'd0, 8'h02);
        wr(6'd1, 8'h7F);
        for (int k = 2; k < 64; k++) wr(6'(k), 8'((k * 7 + 3) & 8'hFF));
        start_frame(32'h8E89BED6, 6'd12, 24'hABCDEF, nbits, len);
        finish_frame("saturated", nbits, len);
        chk("saturated_len_const", 32'(nbits), 32'd576);
        chk("saturated_pl_const", 32'(payload_length), 32'd62);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
